// File: rtl/fma_pkg.sv
// Shared widths, rounding-mode encodings and record types for the FMA front end.
// No ports: imported by fp_classify and fma_operand_unpacker.
// Pure declarations, no logic or state.
package fma_pkg;

    localparam int PARM_EXP     = 8;
    localparam int PARM_MANT    = 23;
    localparam int PARM_RM      = 3;
    localparam int PARM_EXP_EFF = PARM_EXP + 2;

    localparam logic [PARM_RM-1:0] RM_RNE = 3'b000;
    localparam logic [PARM_RM-1:0] RM_RTZ = 3'b001;
    localparam logic [PARM_RM-1:0] RM_RDN = 3'b010;
    localparam logic [PARM_RM-1:0] RM_RUP = 3'b011;
    localparam logic [PARM_RM-1:0] RM_RMM = 3'b100;
    localparam logic [PARM_RM-1:0] RM_DYN = 3'b111;
    localparam logic [PARM_RM-1:0] PARM_RM_DYN = RM_DYN;

    // Only the quiet bit is set in the canonical NaN fraction.
    localparam logic [PARM_MANT-1:0] CANON_NAN_FRAC = 23'h400000;

    typedef struct packed {
        logic                    sign;
        logic [PARM_EXP-1:0]     exp_raw;
        logic [PARM_EXP_EFF-1:0] exp_eff;
        logic [PARM_MANT:0]      mant;
        logic                    den;
        logic                    zero;
        logic                    inf;
        logic                    nan;
        logic                    snan;
    } fp_unpk_t;

    typedef struct packed {
        fp_unpk_t           a;
        fp_unpk_t           b;
        fp_unpk_t           c;
        logic               sub_sign;
        logic [PARM_RM-1:0] rm;
        logic               rm_illegal;
    } fma_bundle_t;

    // Encodings above RMM (101, 110, 111) are reserved.
    function automatic logic rm_is_illegal(input logic [PARM_RM-1:0] rm);
        return (rm > RM_RMM);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits one packed single-precision operand into fields and class flags.
// Ports: op_i (32-bit packed operand) -> unpk_o (fp_unpk_t record).
// Purely combinational, no backpressure.
module fp_classify
    import fma_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_unpk_t    unpk_o
);

    logic [PARM_EXP-1:0]  exp_fld;
    logic [PARM_MANT-1:0] frac_fld;
    logic                 exp_zero;
    logic                 exp_ones;
    logic                 frac_zero;

    assign exp_fld   = op_i[PARM_EXP+PARM_MANT-1:PARM_MANT];
    assign frac_fld  = op_i[PARM_MANT-1:0];
    assign exp_zero  = (exp_fld == '0);
    assign exp_ones  = (exp_fld == '1);
    assign frac_zero = (frac_fld == '0);

    always_comb begin
        unpk_o         = '0;
        unpk_o.sign    = op_i[31];
        unpk_o.exp_raw = exp_fld;
        // Denormals and zero share the minimum normal exponent of 1.
        unpk_o.exp_eff = exp_zero ? PARM_EXP_EFF'(1) : PARM_EXP_EFF'(exp_fld);
        unpk_o.mant    = {~exp_zero, frac_fld};
        unpk_o.zero    = exp_zero & frac_zero;
        unpk_o.den     = exp_zero & ~frac_zero;
        unpk_o.inf     = exp_ones & frac_zero;
        unpk_o.nan     = exp_ones & ~frac_zero;
        // Signalling when the quiet bit is clear.
        unpk_o.snan    = exp_ones & ~frac_zero & ((frac_fld & CANON_NAN_FRAC) == '0);
    end

endmodule

// File: rtl/fma_operand_unpacker.sv
// Unpacks/classifies A,B,C, resolves rounding mode and effective-subtract sign.
// Latency 1 cycle, throughput 1/cycle; 2-entry skid buffer, in_ready_o registered.
// Backpressure: stalls hold outputs; one extra bundle is caught in skid, then in_ready_o drops.
// Ports: clk_i/rst_i (sync active-high); in_valid_i/in_ready_o, A_i/B_i/C_i, Rm_i, Frm_i in;
//        out_valid_o/out_ready_i, per-operand sign/exp/mant/class flags, Sub_Sign_o,
//        Rounding_mode_o, Rm_illegal_o out.
module fma_operand_unpacker
    import fma_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic [31:0] C_i,
    input  logic [2:0]  Rm_i,
    input  logic [2:0]  Frm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        A_Sign_o,
    output logic [7:0]  A_Exp_raw_o,
    output logic [9:0]  A_Exp_eff_o,
    output logic [23:0] A_Mant_o,
    output logic        A_DeN_o,
    output logic        A_Zero_o,
    output logic        A_Inf_o,
    output logic        A_NaN_o,
    output logic        A_SNaN_o,
    output logic        B_Sign_o,
    output logic [7:0]  B_Exp_raw_o,
    output logic [9:0]  B_Exp_eff_o,
    output logic [23:0] B_Mant_o,
    output logic        B_DeN_o,
    output logic        B_Zero_o,
    output logic        B_Inf_o,
    output logic        B_NaN_o,
    output logic        B_SNaN_o,
    output logic        C_Sign_o,
    output logic [7:0]  C_Exp_raw_o,
    output logic [9:0]  C_Exp_eff_o,
    output logic [23:0] C_Mant_o,
    output logic        C_DeN_o,
    output logic        C_Zero_o,
    output logic        C_Inf_o,
    output logic        C_NaN_o,
    output logic        C_SNaN_o,
    output logic        Sub_Sign_o,
    output logic [2:0]  Rounding_mode_o,
    output logic        Rm_illegal_o
);

    fp_unpk_t    a_unpk, b_unpk, c_unpk;
    fma_bundle_t new_bndl;
    logic [2:0]  rm_res;

    fp_classify u_cls_a (.op_i(A_i), .unpk_o(a_unpk));
    fp_classify u_cls_b (.op_i(B_i), .unpk_o(b_unpk));
    fp_classify u_cls_c (.op_i(C_i), .unpk_o(c_unpk));

    assign rm_res = (Rm_i == PARM_RM_DYN) ? Frm_i : Rm_i;

    always_comb begin
        new_bndl            = '0;
        new_bndl.a          = a_unpk;
        new_bndl.b          = b_unpk;
        new_bndl.c          = c_unpk;
        new_bndl.sub_sign   = a_unpk.sign ^ b_unpk.sign ^ c_unpk.sign;
        new_bndl.rm         = rm_res;
        new_bndl.rm_illegal = rm_is_illegal(rm_res);
    end

    fma_bundle_t main_q, main_d, skid_q, skid_d;
    logic        main_vld_q, main_vld_d;
    logic        skid_vld_q, skid_vld_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;

    assign accept = in_valid_i & in_ready_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            // Main is necessarily full here and no accept can happen.
            if (out_ready_i) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || out_ready_i) begin
                main_d     = new_bndl;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = new_bndl;
                skid_vld_d = 1'b1;
            end
        end else if (main_vld_q && out_ready_i) begin
            main_vld_d = 1'b0;
        end
        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = main_vld_q;
    assign Sub_Sign_o      = main_q.sub_sign;
    assign Rounding_mode_o = main_q.rm;
    assign Rm_illegal_o    = main_q.rm_illegal;

    assign A_Sign_o    = main_q.a.sign;
    assign A_Exp_raw_o = main_q.a.exp_raw;
    assign A_Exp_eff_o = main_q.a.exp_eff;
    assign A_Mant_o    = main_q.a.mant;
    assign A_DeN_o     = main_q.a.den;
    assign A_Zero_o    = main_q.a.zero;
    assign A_Inf_o     = main_q.a.inf;
    assign A_NaN_o     = main_q.a.nan;
    assign A_SNaN_o    = main_q.a.snan;

    assign B_Sign_o    = main_q.b.sign;
    assign B_Exp_raw_o = main_q.b.exp_raw;
    assign B_Exp_eff_o = main_q.b.exp_eff;
    assign B_Mant_o    = main_q.b.mant;
    assign B_DeN_o     = main_q.b.den;
    assign B_Zero_o    = main_q.b.zero;
    assign B_Inf_o     = main_q.b.inf;
    assign B_NaN_o     = main_q.b.nan;
    assign B_SNaN_o    = main_q.b.snan;

    assign C_Sign_o    = main_q.c.sign;
    assign C_Exp_raw_o = main_q.c.exp_raw;
    assign C_Exp_eff_o = main_q.c.exp_eff;
    assign C_Mant_o    = main_q.c.mant;
    assign C_DeN_o     = main_q.c.den;
    assign C_Zero_o    = main_q.c.zero;
    assign C_Inf_o     = main_q.c.inf;
    assign C_NaN_o     = main_q.c.nan;
    assign C_SNaN_o    = main_q.c.snan;

endmodule

// File: doc/fma_operand_unpacker.md
Name: fma_operand_unpacker

Overview:
- Front-end stage of the single-precision FMA datapath (result = A + B*C). Accepts packed IEEE-754 operands A, B, C and a rounding-mode request.
- Splits each operand into sign/exponent/mantissa-with-hidden-bit and classifies it (zero, denormal, inf, qNaN, sNaN).
- Resolves dynamic rounding mode and the effective-subtract sign.
- Presents results through a valid/ready pipeline with a 2-entry skid buffer, so in_ready_o is registered; it feeds the multiplier/aligner and, downstream, the rounder.

Parameters:
- PARM_EXP, 8, exponent field width
- PARM_MANT, 23, stored mantissa width
- PARM_RM, 3, rounding-mode field width
- PARM_RM_DYN, 3'b111, instruction rm code selecting frm_i

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  operand bundle valid
- in_ready_o  output  1  stage can accept (registered)
- A_i, B_i, C_i  input  32 each  packed operands
- Rm_i  input  3  instruction rounding mode
- Frm_i  input  3  CSR frm, used when Rm_i == DYN
- out_valid_o  output  1  unpacked bundle valid
- out_ready_i  input  1  downstream accepts
- X_Sign_o (X=A,B,C)  output  1 each  sign bit
- X_Exp_raw_o  output  8 each  raw exponent field
- X_Exp_eff_o  output  10 each  effective exponent: field, or 1 if denormal/zero
- X_Mant_o  output  24 each  {hidden bit, fraction}; hidden = (exp != 0)
- X_DeN_o, X_Zero_o, X_Inf_o, X_NaN_o, X_SNaN_o  output  1 each  class flags
- Sub_Sign_o  output  1  A_Sign ^ B_Sign ^ C_Sign
- Rounding_mode_o  output  3  resolved mode (never DYN)
- Rm_illegal_o  output  1  resolved mode is 101/110/111

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - out_valid_o=0, in_ready_o=1, both buffer entries empty, all data outputs 0.
  - In-flight bundles are discarded.
- Classification (combinational, per operand):
  - Zero: exp==0 and frac==0.
  - DeN: exp==0 and frac!=0.
  - Inf: exp==FF and frac==0.
  - NaN: exp==FF and frac!=0.
  - SNaN: NaN and frac[22]==0.
  - The flags are mutually exclusive, except NaN/SNaN which overlap.
- Rounding-mode resolution:
  - Rm_i==DYN: mode = Frm_i; otherwise mode = Rm_i.
  - Rm_illegal_o=1 when the resolved mode is 101, 110 or 111; Rounding_mode_o still carries that value.
- Handshake:
  - Transfer in when in_valid_i & in_ready_o; transfer out when out_valid_o & out_ready_i.
  - Latency: an accepted bundle appears at the outputs on the next cycle; throughput 1/cycle while out_ready_i=1.
- Buffer:
  - Main register drives the outputs; the skid register catches the one bundle accepted while the main register was stalled.
  - in_ready_o(next) = skid empty after this cycle's updates.
- Buffer state transitions:
  - Main empty, accept: load main.
  - Main full, out_ready_i=1, accept: main <= new.
  - Main full, out_ready_i=0, accept: skid <= new; in_ready_o drops next cycle.
  - Main full, out_ready_i=1, skid full: main <= skid; skid empties; in_ready_o rises next cycle.
  - Both full and no drain: hold; no accept is possible because in_ready_o=0.
- Ordering is strict FIFO. Outputs hold stable while out_valid_o & ~out_ready_i.
- Inputs with in_valid_i=0, or presented while in_ready_o=0, are ignored.

Decomposition:
- Shared package fma_pkg:
  - Widths PARM_EXP/PARM_MANT/PARM_RM.
  - RM encodings RNE/RTZ/RDN/RUP/RMM/DYN.
  - Canonical NaN fraction 23'h400000.
  - Packed typedef for the unpacked operand record (sign, exp_raw, exp_eff, mant, 5 flags).
- One combinational sub-module, fp_classify: 32-bit in, unpacked record out, instantiated three times. Buffer logic stays in the top.

Test Plan:
- A=3F800000, B=00000001, C=7F800000, Rm=000 → A: sign0, exp_raw 7F, mant 800000, no flags. B: DeN=1, exp_eff 1, mant 000001. C: Inf=1. All valid one cycle after accept.
- B=7FA00000, C=FFC00000, A=80000000 → B: NaN=1, SNaN=1. C: NaN=1, SNaN=0. A: Zero=1, sign1. Sub_Sign_o = 1^0^1 = 0.
- Rm_i=111 with Frm_i=011 → Rounding_mode_o=011, Rm_illegal_o=0. Frm_i=101 → Rounding_mode_o=101, Rm_illegal_o=1. Rm_i=110 → Rm_illegal_o=1.
- Backpressure: out_ready_i=0, in_valid_i=1 with tags 1,2,3 (in A_i) → 1 and 2 accepted, in_ready_o=0 from cycle 3. Raise out_ready_i → outputs 1,2,3 in order, no loss, no duplicate; in_ready_o returns to 1 one cycle after skid drains.
- Streaming: out_ready_i=1, 16 back-to-back bundles → 16 consecutive out_valid_o cycles, in_ready_o constantly 1.
- rst_i pulsed with both entries full → next cycle out_valid_o=0, in_ready_o=1, outputs zero; the following accepted bundle emerges normally.
